// File: rtl/easyaxi_rsp_sched_pkg.sv
// Shared types and helpers for the EasyAXI response scheduler.
package easyaxi_sched_pkg;

  localparam int OST_DEPTH_DFLT = 16;
  localparam int PTR_WIDTH      = $clog2(OST_DEPTH_DFLT);
  // Widest bitmap the lowest-set-bit helper scans; slot counts above this are unsupported.
  localparam int LSB_MAX        = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_e;

  // Index of the lowest set bit of v, 0 when v is all zeros.
  function automatic int lowest_set(input logic [LSB_MAX-1:0] v);
    int idx;
    idx = 0;
    for (int i = LSB_MAX - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/easyaxi_rsp_sched_if.sv
// Request / order-tracker / response bundle of the EasyAXI response scheduler.
// Handshakes (req_*, rsp_*): a transfer happens on a clock edge where valid
// and ready are both high; once valid is raised, valid and its payload hold
// stable until that edge, and valid never waits on ready.
interface easyaxi_rsp_sched_if
  import easyaxi_sched_pkg::*;
#(
  parameter int OST_DEPTH = OST_DEPTH_DFLT,
  parameter int ID_WIDTH  = 4,
  parameter int LEN_WIDTH = 8
);
  localparam int PW = $clog2(OST_DEPTH);

  logic                 req_valid;
  logic                 req_ready;
  logic [ID_WIDTH-1:0]  req_id;
  logic [LEN_WIDTH-1:0] req_len;
  logic [PW-1:0]        req_ptr;
  logic                 ord_push;
  logic [ID_WIDTH-1:0]  ord_push_id;
  logic [PW-1:0]        ord_push_ptr;
  logic                 ord_pop;
  logic [ID_WIDTH-1:0]  ord_pop_id;
  logic                 ord_pop_last;
  logic [OST_DEPTH-1:0] order_bits;
  logic [OST_DEPTH-1:0] slot_done;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [PW-1:0]        rsp_ptr;
  logic [ID_WIDTH-1:0]  rsp_id;
  logic [LEN_WIDTH-1:0] rsp_beat;
  logic                 rsp_last;
  logic                 dbg_state;

  modport slave (
    input  req_valid, req_id, req_len, order_bits, slot_done, rsp_ready,
    output req_ready, req_ptr, ord_push, ord_push_id, ord_push_ptr,
           ord_pop, ord_pop_id, ord_pop_last,
           rsp_valid, rsp_ptr, rsp_id, rsp_beat, rsp_last, dbg_state
  );

  modport master (
    output req_valid, req_id, req_len, order_bits, slot_done, rsp_ready,
    input  req_ready, req_ptr, ord_push, ord_push_id, ord_push_ptr,
           ord_pop, ord_pop_id, ord_pop_last,
           rsp_valid, rsp_ptr, rsp_id, rsp_beat, rsp_last, dbg_state
  );

endinterface

// File: rtl/easyaxi_rsp_sched_rr_arb.sv
// Combinational round-robin arbiter: first request above last_grant, wrapping.
module easyaxi_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [$clog2(N)-1:0] grant,
  output logic                 grant_valid
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] w_idx;

  // Scan last_grant+1 .. last_grant+N (mod N); last_grant itself is lowest priority.
  always_comb begin
    w_idx       = '0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = 1; i <= N; i++) begin
      w_idx = last_grant + PW'(i);
      if (!grant_valid && req[w_idx]) begin
        grant       = w_idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/easyaxi_rsp_sched.sv
// Outstanding-slot allocator and round-robin response scheduler for an EasyAXI slave port.
module easyaxi_rsp_sched
  import easyaxi_sched_pkg::*;
#(
  parameter int OST_DEPTH = OST_DEPTH_DFLT,
  parameter int ID_WIDTH  = 4,
  parameter int LEN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  easyaxi_rsp_sched_if.slave  bus
);
  localparam int PW = $clog2(OST_DEPTH);

  sched_state_e         r_state, w_state_nxt;
  logic [OST_DEPTH-1:0] r_free, w_free_nxt;
  logic [PW-1:0]        r_rr_ptr;
  logic [PW-1:0]        r_cur;
  logic [LEN_WIDTH-1:0] r_beat;
  logic [ID_WIDTH-1:0]  r_id_mem  [OST_DEPTH];
  logic [LEN_WIDTH-1:0] r_len_mem [OST_DEPTH];

  logic                 w_req_ready;
  logic [PW-1:0]        w_alloc_ptr;
  logic                 w_push;
  logic [OST_DEPTH-1:0] w_elig;
  logic [PW-1:0]        w_pick;
  logic                 w_pick_valid;
  logic                 w_rsp_valid;
  logic                 w_last;
  logic                 w_pop;

  // Allocation: lowest free slot; freed slots only become visible next cycle.
  // The push/pop strobes are masked by reset so the tracker sees nothing then.
  assign w_req_ready = |r_free;
  assign w_alloc_ptr = PW'(lowest_set(LSB_MAX'(r_free)));
  assign w_push      = bus.req_valid & w_req_ready & ~rst;

  // A slot may be returned when it is head of its ID, has data, and is occupied.
  assign w_elig = bus.order_bits & bus.slot_done & ~r_free;

  easyaxi_rr_arb #(.N(OST_DEPTH)) u_arb (
    .req        (w_elig),
    .last_grant (r_rr_ptr),
    .grant      (w_pick),
    .grant_valid(w_pick_valid)
  );

  assign w_last = (r_beat == r_len_mem[r_cur]);
  assign w_pop  = w_rsp_valid & bus.rsp_ready & ~rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and response valid: IDLE picks a burst, BURST streams it out.
  always_comb begin
    w_state_nxt = r_state;
    w_rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) w_state_nxt = BURST;
      end
      BURST: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Free bitmap update: clear on allocate, set on the last response beat.
  always_comb begin
    w_free_nxt = r_free;
    if (w_push)          w_free_nxt[w_alloc_ptr] = 1'b0;
    if (w_pop && w_last) w_free_nxt[r_cur]       = 1'b1;
  end

  // Slot bookkeeping, current burst and beat counter, round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_free   <= '1;
      r_rr_ptr <= PW'(OST_DEPTH - 1);
      r_cur    <= '0;
      r_beat   <= '0;
    end else begin
      r_free <= w_free_nxt;
      if (r_state == IDLE && w_pick_valid) begin
        r_cur  <= w_pick;
        r_beat <= '0;
      end
      if (w_pop) begin
        if (w_last) r_rr_ptr <= r_cur;
        else        r_beat   <= r_beat + 1'b1;
      end
    end
  end

  // Per-slot request attributes captured on allocation.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_id_mem[w_alloc_ptr]  <= bus.req_id;
      r_len_mem[w_alloc_ptr] <= bus.req_len;
    end
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.req_ptr      = w_alloc_ptr;
  assign bus.ord_push     = w_push;
  assign bus.ord_push_id  = bus.req_id;
  assign bus.ord_push_ptr = w_alloc_ptr;
  assign bus.rsp_valid    = w_rsp_valid;
  assign bus.rsp_ptr      = r_cur;
  assign bus.rsp_id       = r_id_mem[r_cur];
  assign bus.rsp_beat     = r_beat;
  assign bus.rsp_last     = w_rsp_valid & w_last;
  assign bus.ord_pop      = w_pop;
  assign bus.ord_pop_id   = r_id_mem[r_cur];
  assign bus.ord_pop_last = w_rsp_valid & w_last;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_easyaxi_rsp_sched.sv
// Directed bench for easyaxi_rsp_sched with OST_DEPTH=4, ID_WIDTH=2, LEN_WIDTH=8.
module tb_easyaxi_rsp_sched;

  logic clk;
  logic rst;

  easyaxi_rsp_sched_if #(.OST_DEPTH(4), .ID_WIDTH(2), .LEN_WIDTH(8)) bus ();

  easyaxi_rsp_sched #(.OST_DEPTH(4), .ID_WIDTH(2), .LEN_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  // {ptr[1:0], id[1:0], beat[7:0], last}
  logic [12:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, want);
  endtask

  function automatic logic [12:0] mk_beat(input int ptr, input int id, input int beat, input logic last);
    logic [1:0] p;
    logic [1:0] d;
    logic [7:0] b;
    p = 2'(ptr);
    d = 2'(id);
    b = 8'(beat);
    return {p, d, b, last};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_id     = '0;
    bus.req_len    = '0;
    bus.order_bits = '0;
    bus.slot_done  = '0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic alloc(input int id, input int len, input int exp_ptr);
    bus.req_valid = 1'b1;
    bus.req_id    = 2'(id);
    bus.req_len   = 8'(len);
    @(negedge clk);
    check("req_ready", bus.req_ready, 1);
    check("req_ptr", bus.req_ptr, exp_ptr);
    check("ord_push", bus.ord_push, 1);
    check("ord_push_ptr", bus.ord_push_ptr, exp_ptr);
    check("ord_push_id", bus.ord_push_id, id);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic set_bits(input logic [3:0] ord, input logic [3:0] done);
    bus.order_bits = ord;
    bus.slot_done  = done;
  endtask

  // Accept beats with rsp_ready=1 until exp_q drains; counts valid-low cycles seen.
  task automatic drain(input int exp_idle);
    int idle;
    int budget;
    logic [12:0] item;
    idle   = 0;
    budget = 600;
    bus.rsp_ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        item = exp_q.pop_front();
        check("rsp_beat", {bus.rsp_ptr, bus.rsp_id, bus.rsp_beat, bus.rsp_last}, item);
        check("ord_pop", bus.ord_pop, 1);
        check("ord_pop_id", bus.ord_pop_id, item[10:9]);
        check("ord_pop_last", bus.ord_pop_last, item[0]);
      end else begin
        idle++;
      end
      budget--;
      step();
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    check("idle_cycles", idle, exp_idle);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state, including a request offered while reset is high.
    do_reset();
    rst = 1'b1;
    bus.req_valid = 1'b1;
    @(negedge clk);
    check("rst_ord_push", bus.ord_push, 0);
    check("rst_ord_pop", bus.ord_pop, 0);
    step();
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_req_ptr", bus.req_ptr, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_state", bus.dbg_state, 0);
    step();

    // 1. Single burst id=1 len=2 in slot 0.
    alloc(1, 2, 0);
    set_bits(4'b0001, 4'b0001);
    exp_q.push_back(mk_beat(0, 1, 0, 1'b0));
    exp_q.push_back(mk_beat(0, 1, 1, 1'b0));
    exp_q.push_back(mk_beat(0, 1, 2, 1'b1));
    drain(1);
    @(negedge clk);
    check("t1_free_ptr", bus.req_ptr, 0);
    check("t1_rsp_valid", bus.rsp_valid, 0);
    check("t1_state", bus.dbg_state, 0);
    step();
    set_bits(4'b0000, 4'b0000);

    // 2. Fill all slots, then free slot 2 (len=1).
    do_reset();
    for (int i = 0; i < 4; i++) alloc(i, (i == 2) ? 1 : 0, i);
    bus.req_valid = 1'b1;
    @(negedge clk);
    check("t2_full_ready", bus.req_ready, 0);
    check("t2_full_push", bus.ord_push, 0);
    step();
    bus.req_valid = 1'b0;
    set_bits(4'b0100, 4'b0100);
    step();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("t2_beat0", {bus.rsp_valid, bus.rsp_ptr, bus.rsp_beat, bus.rsp_last}, {1'b1, 2'd2, 8'd0, 1'b0});
    step();
    @(negedge clk);
    check("t2_beat1", {bus.rsp_valid, bus.rsp_ptr, bus.rsp_beat, bus.rsp_last}, {1'b1, 2'd2, 8'd1, 1'b1});
    check("t2_no_bypass", bus.req_ready, 0);
    step();
    set_bits(4'b0000, 4'b0000);
    @(negedge clk);
    check("t2_ready_after", bus.req_ready, 1);
    check("t2_ptr_after", bus.req_ptr, 2);
    check("t2_rsp_valid", bus.rsp_valid, 0);
    step();

    // 3. Round robin over all four slots, then re-arm 0 and 3.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(i, 0, i);
    set_bits(4'b1111, 4'b1111);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk_beat(i, i, 0, 1'b1));
    drain(4);
    set_bits(4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) alloc(3 - i, 0, i);
    set_bits(4'b1001, 4'b1001);
    exp_q.push_back(mk_beat(0, 3, 0, 1'b1));
    exp_q.push_back(mk_beat(3, 0, 0, 1'b1));
    drain(2);
    set_bits(4'b0000, 4'b0000);

    // 4. Backpressure for 5 cycles at beat 1 of a len=3 burst.
    do_reset();
    alloc(3, 3, 0);
    set_bits(4'b0001, 4'b0001);
    step();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_beat0", bus.rsp_beat, 0);
    check("t4_pop0", bus.ord_pop, 1);
    step();
    bus.rsp_ready = 1'b0;
    bus.slot_done = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_hold", {bus.rsp_valid, bus.rsp_ptr, bus.rsp_id, bus.rsp_beat, bus.rsp_last},
            {1'b1, 2'd0, 2'd3, 8'd1, 1'b0});
      check("t4_no_pop", bus.ord_pop, 0);
      step();
    end
    for (int b = 1; b <= 3; b++) exp_q.push_back(mk_beat(0, 3, b, b == 3));
    drain(0);
    set_bits(4'b0000, 4'b0000);

    // 5. Same ID in slots 0 and 1; tracker exposes only the head.
    do_reset();
    alloc(2, 1, 0);
    alloc(2, 0, 1);
    set_bits(4'b0001, 4'b0011);
    exp_q.push_back(mk_beat(0, 2, 0, 1'b0));
    exp_q.push_back(mk_beat(0, 2, 1, 1'b1));
    drain(1);
    bus.order_bits = 4'b0010;
    exp_q.push_back(mk_beat(1, 2, 0, 1'b1));
    drain(1);
    set_bits(4'b0000, 4'b0000);

    // 6. Reset at beat 1 of a len=3 burst.
    do_reset();
    alloc(1, 3, 0);
    set_bits(4'b0001, 4'b0001);
    step();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("t6_beat0", bus.rsp_beat, 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("t6_beat1", bus.rsp_beat, 1);
    check("t6_pop_in_rst", bus.ord_pop, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t6_rsp_valid", bus.rsp_valid, 0);
      check("t6_req_ready", bus.req_ready, 1);
      check("t6_req_ptr", bus.req_ptr, 0);
      check("t6_no_pop", bus.ord_pop, 0);
      step();
    end
    set_bits(4'b0000, 4'b0000);

    // 7. Maximum length burst: 256 beats, last on beat 255.
    do_reset();
    alloc(2, 255, 0);
    set_bits(4'b0001, 4'b0001);
    for (int b = 0; b < 256; b++) exp_q.push_back(mk_beat(0, 2, b, b == 255));
    drain(1);
    @(negedge clk);
    check("t7_free_ptr", bus.req_ptr, 0);
    check("t7_rsp_valid", bus.rsp_valid, 0);
    step();

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
